dsp_mac_seq: RTL and testbench

Stream-side sequencer that drives a single DSP slice as a multiply-accumulate engine. It accepts signed A/B operand pairs over a valid/ready stream and issues them to the slice's A/B ports. It generates an OPMODE word aligned to the slice's multiplier latency, so that `P` accumulates `sum(a_i*b_i)`. It then captures the final `P` into a held result with its own valid/ready handshake. It is the initiator for the DSP slice: it produces the slice's inputs and consumes its `P` output.

---
 rtl/dsp_ctrl_pkg.sv | 28 ++
 rtl/dsp_tag_pipe.sv | 35 +++
 rtl/dsp_mac_seq.sv | 164 ++++++++++++++++
 tb/tb_dsp_mac_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dsp_ctrl_pkg.sv
// rtl/dsp_ctrl_pkg.sv - OPMODE constants, FSM state and tag types for the DSP MAC sequencer
package dsp_ctrl_pkg;

  localparam logic [7:0] OPM_LOAD_M = 8'b0000_0001;
  localparam logic [7:0] OPM_ACC_M  = 8'b0000_1001;
  localparam logic [7:0] OPM_HOLD_P = 8'b0000_1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic v;
    logic first;
    logic last;
    logic err;
  } tag_t;

  // Bubbles keep P; the first element of a vector overwrites it.
  function automatic logic [7:0] tag_opmode(input tag_t t);
    if (!t.v) return OPM_HOLD_P;
    return t.first ? OPM_LOAD_M : OPM_ACC_M;
  endfunction

endpackage

// File: rtl/dsp_tag_pipe.sv
// rtl/dsp_tag_pipe.sv - fixed-depth shift register of element tags tracking the slice pipeline
module dsp_tag_pipe
  import dsp_ctrl_pkg::*;
#(
  parameter int DEPTH = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tap [DEPTH]
);

  tag_t stage_q [DEPTH];
  tag_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tap = stage_q;

endmodule

// File: rtl/dsp_mac_seq.sv
// rtl/dsp_mac_seq.sv - stream sequencer driving one DSP slice as a multiply-accumulate engine
module dsp_mac_seq
  import dsp_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int MAX_LEN = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic signed [17:0]               s_a,
  input  logic signed [17:0]               s_b,
  input  logic                             s_last,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [47:0]                      m_data,
  output logic [$clog2(MAX_LEN+1)-1:0]     m_count,
  output logic                             m_err,
  output logic signed [17:0]               dsp_a,
  output logic signed [17:0]               dsp_b,
  output logic [17:0]                      dsp_d,
  output logic [47:0]                      dsp_c,
  output logic [7:0]                       dsp_opmode,
  output logic                             dsp_ce,
  output logic                             dsp_rst,
  input  logic [47:0]                      dsp_p
);

  localparam int CW    = $clog2(MAX_LEN + 1);
  localparam int DEPTH = MUL_LAT + 3;
  localparam int CAP   = MUL_LAT + 2;
  localparam int DW    = $clog2(MUL_LAT + 3);

  state_t                 state_q, state_d;
  logic                   dsp_rst_q, dsp_rst_d;
  logic                   en_q, en_d;
  logic signed [17:0]     dsp_a_q, dsp_a_d;
  logic signed [17:0]     dsp_b_q, dsp_b_d;
  logic [7:0]             opmode_q, opmode_d;
  logic [CW-1:0]          count_q, count_d;
  logic [DW-1:0]          drain_q, drain_d;
  logic [47:0]            m_data_q, m_data_d;
  logic [CW-1:0]          m_count_q, m_count_d;
  logic                   m_err_q, m_err_d;

  logic                   accept;
  logic                   first;
  logic                   force_last;
  logic                   cap;
  tag_t                   tag_in;
  tag_t                   tap [DEPTH];

  dsp_tag_pipe #(.DEPTH(DEPTH)) u_tags (
    .clk    (clk),
    .rst_n  (rst_n),
    .tag_in (tag_in),
    .tap    (tap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = '0;
    case (state_q)
      ST_IDLE:  if (accept) state_d = tag_in.last ? ST_DRAIN : ST_ACCUM;
      ST_ACCUM: if (accept && tag_in.last) state_d = ST_DRAIN;
      ST_DRAIN: begin
        // Held until the last tag has left the P stage and been captured.
        if (drain_q == DW'(MUL_LAT + 2)) begin
          state_d = ST_HOLD;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      ST_HOLD:  if (m_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready = en_q && (state_q == ST_IDLE || state_q == ST_ACCUM);
    m_valid = (state_q == ST_HOLD);
  end

  always_comb begin
    accept     = s_valid && s_ready;
    first      = (state_q == ST_IDLE);
    count_d    = count_q;
    dsp_a_d    = dsp_a_q;
    dsp_b_d    = dsp_b_q;
    force_last = 1'b0;
    tag_in     = '0;
    if (accept) begin
      count_d    = first ? CW'(1) : count_q + CW'(1);
      force_last = !s_last && (count_d == CW'(MAX_LEN));
      dsp_a_d    = s_a;
      dsp_b_d    = s_b;
      tag_in.v     = 1'b1;
      tag_in.first = first;
      tag_in.last  = s_last || force_last;
      tag_in.err   = force_last;
    end

    opmode_d  = tag_opmode(tap[MUL_LAT]);
    dsp_rst_d = 1'b0;
    en_d      = !dsp_rst_q;

    cap       = tap[CAP].v && tap[CAP].last;
    m_data_d  = m_data_q;
    m_count_d = m_count_q;
    m_err_d   = m_err_q;
    if (cap) begin
      m_data_d  = dsp_p;
      m_count_d = count_q;
      m_err_d   = tap[CAP].err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_rst_q <= 1'b1;
      en_q      <= 1'b0;
      dsp_a_q   <= '0;
      dsp_b_q   <= '0;
      opmode_q  <= OPM_HOLD_P;
      count_q   <= '0;
      m_data_q  <= '0;
      m_count_q <= '0;
      m_err_q   <= 1'b0;
    end else begin
      dsp_rst_q <= dsp_rst_d;
      en_q      <= en_d;
      dsp_a_q   <= dsp_a_d;
      dsp_b_q   <= dsp_b_d;
      opmode_q  <= opmode_d;
      count_q   <= count_d;
      m_data_q  <= m_data_d;
      m_count_q <= m_count_d;
      m_err_q   <= m_err_d;
    end
  end

  assign dsp_a      = dsp_a_q;
  assign dsp_b      = dsp_b_q;
  assign dsp_d      = '0;
  assign dsp_c      = '0;
  assign dsp_opmode = opmode_q;
  assign dsp_ce     = rst_n;
  assign dsp_rst    = dsp_rst_q;
  assign m_data     = m_data_q;
  assign m_count    = m_count_q;
  assign m_err      = m_err_q;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// tb/tb_dsp_mac_seq.sv - directed self-checking bench for dsp_mac_seq with a behavioural DSP slice
module tb_dsp_mac_seq;

  localparam int MUL_LAT = 3;
  localparam int MAX_LEN = 4;
  localparam int CW      = $clog2(MAX_LEN + 1);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic signed [17:0]  s_a = '0;
  logic signed [17:0]  s_b = '0;
  logic                s_last = 1'b0;
  logic                m_valid;
  logic                m_ready = 1'b1;
  logic [47:0]         m_data;
  logic [CW-1:0]       m_count;
  logic                m_err;
  logic signed [17:0]  dsp_a, dsp_b;
  logic [17:0]         dsp_d;
  logic [47:0]         dsp_c;
  logic [7:0]          dsp_opmode;
  logic                dsp_ce, dsp_rst;
  logic [47:0]         dsp_p;

  dsp_mac_seq #(.MUL_LAT(MUL_LAT), .MAX_LEN(MAX_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_a        (s_a),
    .s_b        (s_b),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_count    (m_count),
    .m_err      (m_err),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_d      (dsp_d),
    .dsp_c      (dsp_c),
    .dsp_opmode (dsp_opmode),
    .dsp_ce     (dsp_ce),
    .dsp_rst    (dsp_rst),
    .dsp_p      (dsp_p)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slice model: operands enter one edge after DSP_A changes, then MUL_LAT stages to M.
  logic signed [35:0] prod_pipe [MUL_LAT+1];
  logic [47:0]        p_q = '0;
  logic signed [35:0] m_val;
  assign m_val = prod_pipe[MUL_LAT];
  assign dsp_p = p_q;

  always @(posedge clk) begin
    if (dsp_rst) begin
      for (int i = 0; i <= MUL_LAT; i++) prod_pipe[i] <= '0;
      p_q <= '0;
    end else if (dsp_ce) begin
      prod_pipe[0] <= dsp_a * dsp_b;
      for (int i = 1; i <= MUL_LAT; i++) prod_pipe[i] <= prod_pipe[i-1];
      case (dsp_opmode)
        8'h01:   p_q <= {{12{m_val[35]}}, m_val};
        8'h09:   p_q <= p_q + {{12{m_val[35]}}, m_val};
        default: p_q <= p_q;
      endcase
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int last_acc = 0;

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic signed [17:0] a, input logic signed [17:0] b, input logic last);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    expect_eq("send_ready", s_ready, 1);
    @(posedge clk);
    #1;
    last_acc = cyc;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [47:0] d, input int cnt,
                            input logic err, input int stall);
    int n = 0;
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    expect_eq({tag, "_valid"}, m_valid, 1);
    expect_eq({tag, "_lat"}, cyc - last_acc, MUL_LAT + 3);
    expect_eq({tag, "_data"}, m_data, d);
    expect_eq({tag, "_count"}, m_count, cnt);
    expect_eq({tag, "_err"}, m_err, err);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      expect_eq({tag, "_stall_valid"}, m_valid, 1);
      expect_eq({tag, "_stall_data"}, m_data, d);
      expect_eq({tag, "_stall_sready"}, s_ready, 0);
    end
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    expect_eq({tag, "_hs_done"}, m_valid, 0);
    expect_eq({tag, "_ready_again"}, s_ready, 1);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    expect_eq("rst_s_ready", s_ready, 0);
    expect_eq("rst_m_valid", m_valid, 0);
    expect_eq("rst_m_data", m_data, 0);
    expect_eq("rst_m_count", m_count, 0);
    expect_eq("rst_m_err", m_err, 0);
    expect_eq("rst_dsp_a", dsp_a, 0);
    expect_eq("rst_opmode", dsp_opmode, 8'h08);
    expect_eq("rst_dsp_ce", dsp_ce, 0);
    expect_eq("rst_dsp_rst", dsp_rst, 1);

    rst_n = 1'b1;
    #1;
    expect_eq("rel_dsp_ce", dsp_ce, 1);
    expect_eq("rel_dsp_rst", dsp_rst, 1);
    @(posedge clk); #1;
    expect_eq("rel1_dsp_rst", dsp_rst, 0);
    expect_eq("rel1_s_ready", s_ready, 0);
    @(posedge clk); #1;
    expect_eq("rel2_s_ready", s_ready, 1);

    send(2, 4, 0);
    send(3, 5, 1);
    get_result("dot23", 48'd23, 2, 0, 0);

    send(-3, 7, 0);
    send(5, 5, 1);
    get_result("dot4", 48'd4, 2, 0, 0);

    send(-131072, -131072, 1);
    get_result("single", 48'h4_0000_0000, 1, 0, 0);

    send(1, 1, 0);
    @(negedge clk);
    send(1, 2, 0);
    @(negedge clk);
    send(1, 3, 1);
    get_result("bubble", 48'd6, 3, 0, 0);

    m_ready = 1'b0;
    send(10, 3, 0);
    send(-2, 4, 1);
    get_result("stall", 48'd22, 2, 0, 5);
    send(3, 3, 1);
    get_result("after_stall", 48'd9, 1, 0, 0);

    for (int i = 0; i < 4; i++) send(1, 1, 0);
    get_result("maxlen", 48'd4, 4, 1, 0);
    send(1, 1, 1);
    get_result("after_max", 48'd1, 1, 0, 0);

    send(1, 1, 0);
    send(2, 2, 0);
    @(negedge clk);
    rst_n = 1'b0;
    seen = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_valid) seen++;
    end
    expect_eq("abort_no_valid", seen, 0);
    send(2, 2, 1);
    get_result("post_abort", 48'd4, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
